// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, shifts, rotates and serial I/O.
// Includes clear/preset overrides, a saturating shift counter and a sticky illegal-mode flag.
module univ_shift_reg #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1,
    localparam int             CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_bar,
    input  logic             preset_bar,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained,
    output logic             illegal
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt_inc;

    // Counter parks at WIDTH so a drained word stays drained.
    assign cnt_inc   = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + 1'b1;
    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];
    assign drained   = (shift_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            shift_cnt <= '0;
            illegal   <= 1'b0;
        end else if (!clr_bar) begin
            q         <= '0;
            shift_cnt <= '0;
        end else if (!preset_bar) begin
            q         <= PRESET_VAL;
            shift_cnt <= '0;
        end else if (en) begin
            unique case (mode)
                3'b000: ;
                3'b001: begin
                    q         <= d;
                    shift_cnt <= '0;
                    illegal   <= 1'b0;
                end
                3'b010: begin
                    q         <= {q[WIDTH-2:0], ser_in_l};
                    shift_cnt <= cnt_inc;
                end
                3'b011: begin
                    q         <= {ser_in_r, q[WIDTH-1:1]};
                    shift_cnt <= cnt_inc;
                end
                3'b100: begin
                    q         <= {q[WIDTH-2:0], q[WIDTH-1]};
                    shift_cnt <= cnt_inc;
                end
                3'b101: begin
                    q         <= {q[0], q[WIDTH-1:1]};
                    shift_cnt <= cnt_inc;
                end
                3'b110: begin
                    q         <= {q[WIDTH-1], q[WIDTH-1:1]};
                    shift_cnt <= cnt_inc;
                end
                3'b111: illegal <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register that generalises our single-bit D flip-flop to WIDTH bits. It keeps the synchronous active-low clear/preset overrides and adds parallel load, logical/arithmetic shifts, rotates and serial in/out. A shift counter and a drained flag let a serialiser or deserialiser know when a loaded word has been fully shifted. It sits between datapath registers and serial links or bit-level test logic.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 or more.
PRESET_VAL, all ones (WIDTH bits), value forced by preset_bar.
CNT_W, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
clk  input  1  clock; every state change occurs on its rising edge.
rst  input  1  reset, synchronous and active-high.
en  input  1  operation enable; does not gate clr_bar or preset_bar.
clr_bar  input  1  synchronous clear, active-low.
preset_bar  input  1  synchronous preset, active-low.
mode  input  3  operation select; encoding is given under Behaviour.
d  input  WIDTH  parallel load data.
ser_in_l  input  1  bit shifted into the LSB on a left shift.
ser_in_r  input  1  bit shifted into the MSB on a logical right shift.
q  output  WIDTH  register contents.
ser_out_l  output  1  q[WIDTH-1]; combinational from q.
ser_out_r  output  1  q[0]; combinational from q.
shift_cnt  output  CNT_W  number of shift/rotate operations since the last load, clear, preset or reset; saturates at WIDTH.
drained  output  1  (shift_cnt == WIDTH); combinational from the count register.
illegal  output  1  sticky flag for a reserved mode code.

Behaviour:
- All state is registered on the rising edge of clk. Results are visible the cycle after the edge, so latency is 1 cycle. There are no asynchronous paths.
- Priority per edge, highest first: rst, clr_bar==0, preset_bar==0, en==0, mode.
- On rst: q=0, shift_cnt=0, illegal=0. This gives drained=0, ser_out_l=0, ser_out_r=0.
- On clr_bar==0: q=0, shift_cnt=0. illegal is unchanged. This applies regardless of en.
- On clr_bar==0 and preset_bar==0 in the same cycle: clear wins and q=0.
- On preset_bar==0 alone: q=PRESET_VAL, shift_cnt=0. illegal is unchanged. This applies regardless of en.
- On en==0 with no override: all state holds.
- Modes when en==1:
  - 000: hold.
  - 001: load. q=d, shift_cnt=0, illegal=0.
  - 010: shift left. q={q[WIDTH-2:0], ser_in_l}.
  - 011: logical shift right. q={ser_in_r, q[WIDTH-1:1]}.
  - 100: rotate left. q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101: rotate right. q={q[0], q[WIDTH-1:1]}.
  - 110: arithmetic shift right. q={q[WIDTH-1], q[WIDTH-1:1]}.
  - 111: reserved. q holds and illegal is set to 1.
- Modes 010 through 110 increment shift_cnt by 1, saturating at WIDTH. Once saturated the count stays at WIDTH; it does not wrap. Hold and reserved leave the count unchanged.
- illegal is cleared only by rst or by a load. clr_bar and preset_bar do not clear it.
- rst or clr_bar asserted mid-sequence takes effect on that edge. The partial shift is discarded and shift_cnt returns to 0.
- Values of ser_in_l and ser_in_r are ignored outside their own modes.

Test Plan:
(All scenarios use WIDTH=8.)
1. Assert rst=1 for 1 cycle with d=0xFF, mode=001, en=1 -> q=0x00, shift_cnt=0, drained=0, illegal=0. rst has priority over the load.
2. Load 0xA5, then 8 cycles of mode=010 with ser_in_l=0 -> q=0x4A, 0x94, 0x28, 0x50, 0xA0, 0x40, 0x80, 0x00 and shift_cnt=1..8. drained=1 after the 8th shift. A 9th shift leaves shift_cnt=8.
3. Load 0x81, then mode=101 -> q=0xC0, 0x60. Then mode=110 from 0x80 -> q=0xC0, 0xE0. Then mode=011 with ser_in_r=1 from 0x00 -> q=0x80.
4. With mode=001, d=0x3C, en=1: clr_bar=0 and preset_bar=0 together -> q=0x00. preset_bar=0 alone -> q=0xFF. preset_bar=0 with en=0 -> q=0xFF, shift_cnt=0.
5. Load 0x5A, then mode=111 -> q stays 0x5A and illegal=1 the next cycle. illegal stays 1 through shifts and through clr_bar=0. A load of 0x11 clears it (illegal=0, q=0x11).
6. Load 0xF0, apply 3 shift-lefts (shift_cnt=3), then rst=1 -> q=0x00, shift_cnt=0 on that edge. Then en=0 with mode=010 for 2 cycles -> q=0x00 and shift_cnt=0 hold.
